// File: rtl/if_fetch_queue_pkg.sv
// Shared types for the instruction fetch queue: entry layout, FSM states and the reset NOP.
package if_fetch_queue_pkg;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam int          PC_W = 32;

  typedef enum logic {RUN, DRAIN} fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
    logic            filled;
  } fq_entry_t;

  localparam fq_entry_t EMPTY_ENTRY = '{pc: '0, instr: NOP, filled: 1'b0};

endpackage

// File: rtl/if_fetch_queue_if.sv
// Memory request/response and decode handshake bundle between the fetch queue and its neighbours.
interface if_fetch_queue_if #(parameter int W = 32);

  logic         imem_req_valid;
  logic         imem_req_ready;
  logic [W-1:0] imem_addr;
  logic         imem_rsp_valid;
  logic [31:0]  imem_rsp_data;
  logic         id_valid;
  logic         id_ready;
  logic [31:0]  id_instr;
  logic [W-1:0] id_pc;

  modport master (
    output imem_req_valid, imem_addr, id_valid, id_instr, id_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, id_valid, id_instr, id_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready
  );

endinterface

// File: rtl/if_fetch_queue_ring.sv
// DEPTH-entry in-order ring: entries are allocated on request, filled on response, freed by decode.
module if_fetch_queue_ring
  import if_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             alloc_i,
  input  logic [PC_W-1:0]  alloc_pc_i,
  input  logic             fill_i,
  input  logic [31:0]      fill_data_i,
  input  logic             deq_i,
  output fq_entry_t        head_o,
  output logic [CW-1:0]    occ_o,
  output logic [CW-1:0]    pend_o
);

  localparam int PW = $clog2(DEPTH);

  fq_entry_t         entries [DEPTH];
  logic [PW-1:0]     alloc_q, fill_q, head_q;
  logic [CW-1:0]     occ_q, pend_q;

  // pend tracks allocated-but-unfilled entries so the top can count in-flight requests on a flush
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      entries <= '{default: EMPTY_ENTRY};
      alloc_q <= '0;
      fill_q  <= '0;
      head_q  <= '0;
      occ_q   <= '0;
      pend_q  <= '0;
    end else if (clear_i) begin
      entries <= '{default: EMPTY_ENTRY};
      alloc_q <= '0;
      fill_q  <= '0;
      head_q  <= '0;
      occ_q   <= '0;
      pend_q  <= '0;
    end else begin
      if (deq_i) begin
        entries[head_q].filled <= 1'b0;
        head_q                 <= head_q + PW'(1);
      end
      if (alloc_i) begin
        entries[alloc_q].pc     <= alloc_pc_i;
        entries[alloc_q].filled <= 1'b0;
        alloc_q                 <= alloc_q + PW'(1);
      end
      if (fill_i) begin
        entries[fill_q].instr  <= fill_data_i;
        entries[fill_q].filled <= 1'b1;
        fill_q                 <= fill_q + PW'(1);
      end
      occ_q  <= occ_q + CW'(alloc_i) - CW'(deq_i);
      pend_q <= pend_q + CW'(alloc_i) - CW'(fill_i);
    end
  end

  assign head_o = entries[head_q];
  assign occ_o  = occ_q;
  assign pend_o = pend_q;

endmodule

// File: rtl/if_fetch_queue.sv
// Fetch stage: issues in-order instruction requests for pc_i, queues responses for decode,
// and drops responses belonging to requests that a redirect has killed.
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [W-1:0]    pc_i,
  output logic            pc_stall_o,
  input  logic            flush_i,
  if_fetch_queue_if.master bus
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_e   state_q;
  logic [CW-1:0]  drop_q;
  logic [CW-1:0]  occ, pend;
  fq_entry_t      head;
  logic           credit, req_fire, rsp_fill, deq;
  logic [CW:0]    inflight;

  // Credit counts responses still owed for killed requests, so new work never overruns the ring
  always_comb begin
    credit              = ({1'b0, occ} + {1'b0, drop_q}) < (CW+1)'(DEPTH);
    bus.imem_req_valid  = rst_ni & credit & ~flush_i;
    bus.imem_addr       = pc_i;
    req_fire            = bus.imem_req_valid & bus.imem_req_ready;
    pc_stall_o          = ~flush_i & ~req_fire;
    bus.id_valid        = head.filled & (occ != '0) & ~flush_i;
    bus.id_instr        = head.instr;
    bus.id_pc           = W'(head.pc);
    deq                 = bus.id_valid & bus.id_ready;
    rsp_fill            = bus.imem_rsp_valid & (state_q == RUN) & ~flush_i;
    inflight            = {1'b0, drop_q} + {1'b0, pend} - (CW+1)'(bus.imem_rsp_valid);
  end

  if_fetch_queue_ring #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_ring (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (flush_i),
    .alloc_i     (req_fire),
    .alloc_pc_i  (PC_W'(pc_i)),
    .fill_i      (rsp_fill),
    .fill_data_i (bus.imem_rsp_data),
    .deq_i       (deq),
    .head_o      (head),
    .occ_o       (occ),
    .pend_o      (pend)
  );

  // A response arriving in the flush cycle is one fewer to drop, whichever state we are in
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RUN;
      drop_q  <= '0;
    end else if (flush_i) begin
      drop_q  <= inflight[CW-1:0];
      state_q <= (inflight != '0) ? DRAIN : RUN;
    end else if (state_q == DRAIN && bus.imem_rsp_valid) begin
      drop_q <= drop_q - CW'(1);
      if (drop_q == CW'(1)) state_q <= RUN;
    end
  end

  rsp_has_slot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (bus.imem_rsp_valid && state_q == RUN) |-> (pend != '0));

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue (DEPTH=2) with a fixed-latency in-order memory model.
module tb_if_fetch_queue;
  import if_fetch_queue_pkg::*;

  logic        clk_i   = 1'b0;
  logic        rst_ni  = 1'b0;
  logic [31:0] pc_i    = '0;
  logic        flush_i = 1'b0;
  logic        pc_stall_o;

  if_fetch_queue_if #(.W(32)) bus ();

  if_fetch_queue #(.W(32), .DEPTH(2)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .pc_i       (pc_i),
    .pc_stall_o (pc_stall_o),
    .flush_i    (flush_i),
    .bus        (bus.master)
  );

  always #5 clk_i = ~clk_i;

  int          total = 0;
  int          bad   = 0;
  int          lat   = 1;
  int          cyc   = 0;
  logic [31:0] redirect = '0;

  typedef struct {int due; logic [31:0] data;} rsp_t;
  rsp_t        rq[$];
  logic        hs_q    = 1'b0;
  logic [31:0] hs_addr = '0;

  // Memory model: instruction word is C0DE in the top half and the address in the bottom half
  always @(negedge clk_i) begin
    hs_q    = rst_ni && bus.imem_req_valid && bus.imem_req_ready;
    hs_addr = bus.imem_addr;
  end

  always @(posedge clk_i) begin
    rsp_t r;
    #1;
    cyc++;
    if (!rst_ni) begin
      rq.delete();
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
    end else begin
      if (hs_q) rq.push_back('{cyc + lat - 1, 32'hC0DE_0000 | hs_addr});
      if (rq.size() > 0 && rq[0].due <= cyc) begin
        r = rq.pop_front();
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = r.data;
      end else begin
        bus.imem_rsp_valid = 1'b0;
      end
    end
  end

  task automatic do_reset();
    rst_ni             = 1'b0;
    flush_i            = 1'b0;
    pc_i               = '0;
    bus.imem_req_ready = 1'b0;
    bus.id_ready       = 1'b0;
    repeat (2) @(posedge clk_i);
    #2;
    rst_ni = 1'b1;
  endtask

  // Acts as the PC register: loads the redirect on flush, otherwise advances unless stalled
  task automatic tick();
    logic st, fl;
    st = pc_stall_o;
    fl = flush_i;
    @(posedge clk_i);
    #2;
    flush_i = 1'b0;
    if (fl) pc_i = redirect;
    else if (!st) pc_i = pc_i + 32'd4;
  endtask

  task automatic test_reset();
    rst_ni             = 1'b0;
    flush_i            = 1'b0;
    pc_i               = 32'h40;
    bus.imem_req_ready = 1'b1;
    bus.id_ready       = 1'b1;
    @(posedge clk_i);
    #3;
    total++;
    if ({bus.imem_req_valid, pc_stall_o, bus.id_valid} !== 3'b010) begin
      bad++;
      $display("[TB] FAIL reset flags got=%b want=%b", {bus.imem_req_valid, pc_stall_o, bus.id_valid}, 3'b010);
    end
    total++;
    if (bus.id_instr !== NOP) begin
      bad++;
      $display("[TB] FAIL reset instr got=%h want=%h", bus.id_instr, NOP);
    end
    total++;
    if (bus.id_pc !== 32'h0) begin
      bad++;
      $display("[TB] FAIL reset pc got=%h want=%h", bus.id_pc, 32'h0);
    end
  endtask

  task automatic test_stream();
    logic [2:0]  ef [6] = '{3'b100, 3'b100, 3'b011, 3'b101, 3'b100, 3'b011};
    logic [31:0] ea [6] = '{32'h0, 32'h4, 32'h0, 32'h8, 32'hC, 32'h0};
    logic [31:0] ep [6] = '{32'h0, 32'h0, 32'h0, 32'h4, 32'h0, 32'h8};
    do_reset();
    lat = 1;
    bus.imem_req_ready = 1'b1;
    bus.id_ready       = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      total++;
      if ({bus.imem_req_valid, pc_stall_o, bus.id_valid} !== ef[c]) begin
        bad++;
        $display("[TB] FAIL stream c%0d flags got=%b want=%b", c, {bus.imem_req_valid, pc_stall_o, bus.id_valid}, ef[c]);
      end
      if (ef[c][2]) begin
        total++;
        if (bus.imem_addr !== ea[c]) begin
          bad++;
          $display("[TB] FAIL stream c%0d addr got=%h want=%h", c, bus.imem_addr, ea[c]);
        end
      end
      if (ef[c][0]) begin
        total++;
        if (bus.id_pc !== ep[c] || bus.id_instr !== (32'hC0DE_0000 | ep[c])) begin
          bad++;
          $display("[TB] FAIL stream c%0d id got=%h/%h want=%h/%h", c, bus.id_pc, bus.id_instr, ep[c], 32'hC0DE_0000 | ep[c]);
        end
      end
      tick();
    end
  endtask

  task automatic test_decode_stall();
    logic [2:0]  ef [8] = '{3'b100, 3'b100, 3'b011, 3'b011, 3'b011, 3'b011, 3'b011, 3'b101};
    logic [31:0] ep [8] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h4};
    do_reset();
    lat = 1;
    bus.imem_req_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      bus.id_ready = (c >= 6);
      #1;
      total++;
      if ({bus.imem_req_valid, pc_stall_o, bus.id_valid} !== ef[c]) begin
        bad++;
        $display("[TB] FAIL dstall c%0d flags got=%b want=%b", c, {bus.imem_req_valid, pc_stall_o, bus.id_valid}, ef[c]);
      end
      if (ef[c][0]) begin
        total++;
        if (bus.id_pc !== ep[c] || bus.id_instr !== (32'hC0DE_0000 | ep[c])) begin
          bad++;
          $display("[TB] FAIL dstall c%0d id got=%h/%h want=%h/%h", c, bus.id_pc, bus.id_instr, ep[c], 32'hC0DE_0000 | ep[c]);
        end
      end
      tick();
    end
  endtask

  task automatic test_req_backpressure();
    logic [2:0]  ef [6] = '{3'b110, 3'b110, 3'b110, 3'b100, 3'b100, 3'b011};
    logic [31:0] ea [6] = '{32'h100, 32'h100, 32'h100, 32'h100, 32'h104, 32'h0};
    do_reset();
    lat = 1;
    bus.id_ready = 1'b1;
    pc_i = 32'h100;
    for (int c = 0; c < 6; c++) begin
      bus.imem_req_ready = (c >= 3);
      #1;
      total++;
      if ({bus.imem_req_valid, pc_stall_o, bus.id_valid} !== ef[c]) begin
        bad++;
        $display("[TB] FAIL bpress c%0d flags got=%b want=%b", c, {bus.imem_req_valid, pc_stall_o, bus.id_valid}, ef[c]);
      end
      if (ef[c][2]) begin
        total++;
        if (bus.imem_addr !== ea[c]) begin
          bad++;
          $display("[TB] FAIL bpress c%0d addr got=%h want=%h", c, bus.imem_addr, ea[c]);
        end
      end
      if (ef[c][0]) begin
        total++;
        if (bus.id_pc !== 32'h100 || bus.id_instr !== 32'hC0DE_0100) begin
          bad++;
          $display("[TB] FAIL bpress c%0d id got=%h/%h want=%h/%h", c, bus.id_pc, bus.id_instr, 32'h100, 32'hC0DE_0100);
        end
      end
      tick();
    end
  endtask

  task automatic test_flush();
    logic [2:0]  ef [10] = '{3'b100, 3'b100, 3'b000, 3'b010, 3'b100, 3'b100, 3'b010, 3'b010, 3'b011, 3'b101};
    logic [31:0] ea [10] = '{32'h0, 32'h4, 32'h0, 32'h0, 32'h200, 32'h204, 32'h0, 32'h0, 32'h0, 32'h208};
    logic [31:0] ep [10] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h200, 32'h204};
    do_reset();
    lat = 3;
    redirect = 32'h200;
    bus.imem_req_ready = 1'b1;
    bus.id_ready       = 1'b1;
    for (int c = 0; c < 10; c++) begin
      flush_i = (c == 2);
      #1;
      total++;
      if ({bus.imem_req_valid, pc_stall_o, bus.id_valid} !== ef[c]) begin
        bad++;
        $display("[TB] FAIL flush c%0d flags got=%b want=%b", c, {bus.imem_req_valid, pc_stall_o, bus.id_valid}, ef[c]);
      end
      if (ef[c][2]) begin
        total++;
        if (bus.imem_addr !== ea[c]) begin
          bad++;
          $display("[TB] FAIL flush c%0d addr got=%h want=%h", c, bus.imem_addr, ea[c]);
        end
      end
      if (ef[c][0]) begin
        total++;
        if (bus.id_pc !== ep[c] || bus.id_instr !== (32'hC0DE_0000 | ep[c])) begin
          bad++;
          $display("[TB] FAIL flush c%0d id got=%h/%h want=%h/%h", c, bus.id_pc, bus.id_instr, ep[c], 32'hC0DE_0000 | ep[c]);
        end
      end
      tick();
    end
  endtask

  task automatic test_flush_with_rsp();
    logic [2:0]  ef [9] = '{3'b100, 3'b100, 3'b010, 3'b000, 3'b100, 3'b100, 3'b010, 3'b010, 3'b011};
    logic [31:0] ea [9] = '{32'h0, 32'h4, 32'h0, 32'h0, 32'h300, 32'h304, 32'h0, 32'h0, 32'h0};
    do_reset();
    lat = 3;
    redirect = 32'h300;
    bus.imem_req_ready = 1'b1;
    bus.id_ready       = 1'b1;
    for (int c = 0; c < 9; c++) begin
      flush_i = (c == 3);
      #1;
      total++;
      if ({bus.imem_req_valid, pc_stall_o, bus.id_valid} !== ef[c]) begin
        bad++;
        $display("[TB] FAIL flushrsp c%0d flags got=%b want=%b", c, {bus.imem_req_valid, pc_stall_o, bus.id_valid}, ef[c]);
      end
      if (ef[c][2]) begin
        total++;
        if (bus.imem_addr !== ea[c]) begin
          bad++;
          $display("[TB] FAIL flushrsp c%0d addr got=%h want=%h", c, bus.imem_addr, ea[c]);
        end
      end
      if (ef[c][0]) begin
        total++;
        if (bus.id_pc !== 32'h300 || bus.id_instr !== 32'hC0DE_0300) begin
          bad++;
          $display("[TB] FAIL flushrsp c%0d id got=%h/%h want=%h/%h", c, bus.id_pc, bus.id_instr, 32'h300, 32'hC0DE_0300);
        end
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    logic [2:0] ef [3] = '{3'b100, 3'b100, 3'b011};
    do_reset();
    lat = 1;
    bus.imem_req_ready = 1'b1;
    bus.id_ready       = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if ({bus.imem_req_valid, pc_stall_o, bus.id_valid} !== ef[c]) begin
        bad++;
        $display("[TB] FAIL areset pre c%0d flags got=%b want=%b", c, {bus.imem_req_valid, pc_stall_o, bus.id_valid}, ef[c]);
      end
      if (c < 2) tick();
    end
    rst_ni = 1'b0;
    pc_i   = '0;
    #1;
    total++;
    if ({bus.imem_req_valid, pc_stall_o, bus.id_valid} !== 3'b010 || bus.id_instr !== NOP || bus.id_pc !== 32'h0) begin
      bad++;
      $display("[TB] FAIL areset mid got=%b/%h/%h want=%b/%h/%h", {bus.imem_req_valid, pc_stall_o, bus.id_valid}, bus.id_instr, bus.id_pc, 3'b010, NOP, 32'h0);
    end
    @(posedge clk_i);
    #2;
    rst_ni       = 1'b1;
    bus.id_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if ({bus.imem_req_valid, pc_stall_o, bus.id_valid} !== ef[c]) begin
        bad++;
        $display("[TB] FAIL areset post c%0d flags got=%b want=%b", c, {bus.imem_req_valid, pc_stall_o, bus.id_valid}, ef[c]);
      end
      if (c == 2) begin
        total++;
        if (bus.id_pc !== 32'h0 || bus.id_instr !== 32'hC0DE_0000) begin
          bad++;
          $display("[TB] FAIL areset post id got=%h/%h want=%h/%h", bus.id_pc, bus.id_instr, 32'h0, 32'hC0DE_0000);
        end
      end
      tick();
    end
  endtask

  initial begin
    bus.imem_req_ready = 1'b0;
    bus.id_ready       = 1'b0;
    test_reset();
    test_stream();
    test_decode_stall();
    test_req_backpressure();
    test_flush();
    test_flush_with_rsp();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
